// File: rtl/tlul_socket_1n_dec.sv
// TL-UL 1:N demultiplexing socket with base/mask address decode,
// outstanding-request tracking and an error responder for unmapped addresses.

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_socket_1n_dec #(
    parameter int unsigned NumDev         = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [31:0] DevBase [NumDev] = '{32'h4000_0000, 32'h4001_0000,
                                                32'h4002_0000, 32'h4003_0000},
    parameter logic [31:0] DevMask [NumDev] = '{4{32'h0000_FFFF}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_h_i,
    output tlul_pkg::tl_d2h_t tl_h_o,
    output tlul_pkg::tl_h2d_t tl_d_o [NumDev],
    input  tlul_pkg::tl_d2h_t tl_d_i [NumDev]
);

    localparam int unsigned    SelW   = $clog2(NumDev + 1);
    localparam int unsigned    CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [SelW-1:0] ErrSel = SelW'(NumDev);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    typedef struct packed {
        logic       valid;
        logic [2:0] opcode;
        logic [7:0] source;
        logic [1:0] size;
    } err_rsp_t;

    logic [SelW-1:0]   sel;
    logic [SelW-1:0]   sel_q;
    logic [CntW-1:0]   cnt_q;
    err_rsp_t          err_q;
    logic              go;
    logic              sel_a_ready;
    logic              a_ready;
    logic              d_valid;
    logic              accept;
    logic              consume;
    tlul_pkg::tl_d2h_t rsp;

    // Address decode: lowest-index matching window wins, no match selects the error device
    always_comb begin
        sel = ErrSel;
        for (int unsigned i = NumDev; i > 0; i--) begin
            if ((tl_h_i.a_address & ~DevMask[i-1]) == (DevBase[i-1] & ~DevMask[i-1])) begin
                sel = SelW'(i - 1);
            end
        end
    end

    // Admission: switching devices waits for a full drain so responses stay in order
    assign go = tl_h_i.a_valid &&
                ((cnt_q == '0) || ((sel == sel_q) && (cnt_q < CntMax)));

    // a_ready of the selected target; the error device has a single response slot
    always_comb begin
        sel_a_ready = !err_q.valid;
        for (int unsigned i = 0; i < NumDev; i++) begin
            if (sel == SelW'(i)) begin
                sel_a_ready = tl_d_i[i].a_ready;
            end
        end
    end

    // A-channel fan-out: every device sees the host request, only the selected one gets a_valid
    always_comb begin
        for (int unsigned i = 0; i < NumDev; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = go && (sel == SelW'(i));
        end
    end

    // D-channel mux on the registered owner, with the error responder as the default source
    always_comb begin
        rsp          = '0;
        rsp.d_valid  = err_q.valid;
        rsp.d_opcode = err_q.opcode;
        rsp.d_size   = err_q.size;
        rsp.d_source = err_q.source;
        rsp.d_data   = '1;
        rsp.d_error  = 1'b1;
        for (int unsigned i = 0; i < NumDev; i++) begin
            if (sel_q == SelW'(i)) begin
                rsp = tl_d_i[i];
            end
        end
    end

    assign a_ready = go && sel_a_ready;
    assign d_valid = rsp.d_valid && (cnt_q != '0);
    assign accept  = tl_h_i.a_valid && a_ready;
    assign consume = d_valid && tl_h_i.d_ready;

    // Host response: muxed D fields, gated d_valid and the admission-qualified a_ready
    always_comb begin
        tl_h_o         = rsp;
        tl_h_o.d_valid = d_valid;
        tl_h_o.a_ready = a_ready;
    end

    // Outstanding counter and owning device
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            if (accept && !consume) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (!accept && consume) begin
                cnt_q <= cnt_q - CntW'(1);
            end
            if (accept) begin
                sel_q <= sel;
            end
        end
    end

    // Error response buffer: loads on an unmapped accept, clears when its response is taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else if (accept && (sel == ErrSel)) begin
            err_q.valid  <= 1'b1;
            err_q.opcode <= (tl_h_i.a_opcode == tlul_pkg::Get) ? tlul_pkg::AccessAckData
                                                               : tlul_pkg::AccessAck;
            err_q.source <= tl_h_i.a_source;
            err_q.size   <= tl_h_i.a_size;
        end else if (consume && (sel_q == ErrSel)) begin
            err_q.valid <= 1'b0;
        end
    end

    // Illegal conditions: stray device responses and counter over/underflow
    for (genvar g = 0; g < NumDev; g++) begin : g_dev_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            tl_d_i[g].d_valid |-> ((cnt_q != '0) && (sel_q == SelW'(g))));
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (accept && !consume) |-> (cnt_q < CntMax));

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (consume && !accept) |-> (cnt_q != '0));

endmodule

// File: tb/tb_tlul_socket_1n_dec.sv
// Randomized bench for tlul_socket_1n_dec with device models and a transaction-level reference.

module tb_tlul_socket_1n_dec;

    localparam int NDEV = 4;
    localparam int MAXO = 4;

    localparam logic [31:0] BASE [NDEV] = '{32'h4000_0000, 32'h4001_0000,
                                            32'h4002_0000, 32'h4003_0000};
    localparam logic [31:0] SPAN = 32'h0000_FFFF;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic              clk;
    logic              rst_n;
    tlul_pkg::tl_h2d_t h_req;
    tlul_pkg::tl_d2h_t h_rsp;
    tlul_pkg::tl_h2d_t d_req [NDEV];
    tlul_pkg::tl_d2h_t d_rsp [NDEV];

    int n_chk = 0;
    int n_err = 0;

    // Device models: in-order queue of accepted requests, held d_valid
    tlul_pkg::tl_h2d_t dev_q [NDEV][$];
    bit                dev_dv [NDEV];

    // Reference: outstanding count, owning target, expected host responses in order
    int   m_cnt;
    int   m_owner;
    rsp_t exp_q[$];

    tlul_pkg::tl_h2d_t cur;
    bit                pending;
    bit                force_first;

    tlul_socket_1n_dec #(
        .NumDev(NDEV),
        .MaxOutstanding(MAXO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .tl_h_i(h_req),
        .tl_h_o(h_rsp),
        .tl_d_o(d_req),
        .tl_d_i(d_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Windows are aligned address ranges [base, base+span]
    function automatic int target(input logic [31:0] a);
        for (int i = 0; i < NDEV; i++) begin
            if (a >= BASE[i] && a <= BASE[i] + SPAN) return i;
        end
        return NDEV;
    endfunction

    function automatic rsp_t dev_answer(input int i, input tlul_pkg::tl_h2d_t r);
        rsp_t x;
        x.op   = (r.a_opcode == 3'h4) ? 3'h1 : 3'h0;
        x.size = r.a_size;
        x.src  = r.a_source;
        x.data = (r.a_opcode == 3'h4) ? (r.a_address + 32'h77 + 32'(i) * 32'h1000)
                                      : (r.a_data ^ 32'h0F0F_0F0F);
        x.err  = 1'b0;
        return x;
    endfunction

    function automatic rsp_t err_answer(input tlul_pkg::tl_h2d_t r);
        rsp_t x;
        x.op   = (r.a_opcode == 3'h4) ? 3'h1 : 3'h0;
        x.size = r.a_size;
        x.src  = r.a_source;
        x.data = 32'hFFFF_FFFF;
        x.err  = 1'b1;
        return x;
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic new_request(input int p_av, input int p_unm, input int dlo, input int dhi);
        int d;
        int k;
        cur = '0;
        cur.a_valid  = roll(p_av);
        k            = $urandom_range(0, 2);
        cur.a_opcode = (k == 0) ? 3'h4 : ((k == 1) ? 3'h0 : 3'h1);
        cur.a_size   = 2'($urandom_range(0, 2));
        cur.a_source = 8'($urandom_range(0, 255));
        cur.a_mask   = 4'hF;
        cur.a_data   = $urandom;
        if (roll(p_unm)) begin
            k = $urandom_range(0, 2);
            cur.a_address = (k == 0) ? (32'hF000_0000 | ($urandom & 32'hFFFF)) :
                            (k == 1) ? (32'h4004_0000 + ($urandom & 32'hFFFC)) : 32'h3FFF_FFFC;
        end else begin
            d = $urandom_range(dlo, dhi);
            cur.a_address = BASE[d] + ($urandom & 32'hFFFC);
        end
        if (force_first) begin
            cur.a_valid   = 1'b1;
            cur.a_opcode  = 3'h4;
            cur.a_address = 32'h4000_0000;
        end
    endtask

    task automatic cycle(input int p_av, input int p_dv, input int p_dr, input int p_unm,
                         input int dlo, input int dhi);
        int            tgt;
        bit            go;
        bit            rdy;
        bit            exp_dv;
        bit            cons;
        logic [NDEV-1:0] exp_av;
        logic [NDEV-1:0] obs_av;
        logic [NDEV-1:0] obs_dr;
        rsp_t          got;
        @(negedge clk);
        if (!pending) new_request(p_av, p_unm, dlo, dhi);
        cur.d_ready = roll(p_dr);
        h_req = cur;
        for (int i = 0; i < NDEV; i++) begin
            d_rsp[i] = '0;
            d_rsp[i].a_ready = roll(70) || (force_first && i == 0);
            if (dev_q[i].size() > 0 && (dev_dv[i] || roll(p_dv))) begin
                rsp_t r;
                r = dev_answer(i, dev_q[i][0]);
                dev_dv[i] = 1'b1;
                d_rsp[i].d_opcode = r.op;
                d_rsp[i].d_size   = r.size;
                d_rsp[i].d_source = r.src;
                d_rsp[i].d_data   = r.data;
                d_rsp[i].d_error  = r.err;
            end else begin
                dev_dv[i] = 1'b0;
            end
            d_rsp[i].d_valid = dev_dv[i];
        end
        #1;
        tgt = target(cur.a_address);
        go  = cur.a_valid && (m_cnt == 0 || (tgt == m_owner && m_cnt < MAXO));
        rdy = go && ((tgt < NDEV) ? d_rsp[tgt].a_ready : (m_cnt == 0));
        chk("a_ready", 64'(h_rsp.a_ready), 64'(rdy));
        if (force_first) chk("first_get_after_reset", 64'(h_rsp.a_ready), 64'(1));
        for (int i = 0; i < NDEV; i++) begin
            exp_av[i] = go && (tgt == i);
            obs_av[i] = d_req[i].a_valid;
            obs_dr[i] = d_req[i].d_ready;
        end
        chk("dev_a_valid", 64'(obs_av), 64'(exp_av));
        chk("dev_d_ready", 64'(obs_dr), 64'({NDEV{cur.d_ready}}));
        if (go && tgt < NDEV) begin
            chk("fwd_addr", 64'(d_req[tgt].a_address), 64'(cur.a_address));
            chk("fwd_data_src", {d_req[tgt].a_data, d_req[tgt].a_source, d_req[tgt].a_opcode},
                {cur.a_data, cur.a_source, cur.a_opcode});
        end
        exp_dv = (m_cnt > 0) && ((m_owner == NDEV) ? 1'b1 : dev_dv[m_owner]);
        chk("d_valid", 64'(h_rsp.d_valid), 64'(exp_dv));
        if (exp_dv && h_rsp.d_valid) begin
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                got = {h_rsp.d_opcode, h_rsp.d_size, h_rsp.d_source, h_rsp.d_data, h_rsp.d_error};
                chk("d_fields", 64'(got), 64'(exp_q[0]));
                chk("d_param_sink", 64'({h_rsp.d_param, h_rsp.d_sink}), 64'(0));
            end
        end
        cons = exp_dv && cur.d_ready;
        @(posedge clk);
        if (cons) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            m_cnt--;
            if (m_owner < NDEV) begin
                if (dev_q[m_owner].size() != 0) void'(dev_q[m_owner].pop_front());
                dev_dv[m_owner] = 1'b0;
            end
        end
        if (rdy) begin
            if (tgt < NDEV) begin
                exp_q.push_back(dev_answer(tgt, cur));
                dev_q[tgt].push_back(cur);
            end else begin
                exp_q.push_back(err_answer(cur));
            end
            m_owner = tgt;
            m_cnt++;
            pending = 1'b0;
        end else begin
            pending = cur.a_valid;
        end
        force_first = 1'b0;
    endtask

    task automatic run(input int n, input int p_av, input int p_dv, input int p_dr,
                       input int p_unm, input int dlo, input int dhi);
        for (int c = 0; c < n; c++) cycle(p_av, p_dv, p_dr, p_unm, dlo, dhi);
    endtask

    task automatic clear_models();
        m_cnt   = 0;
        m_owner = 0;
        exp_q.delete();
        pending = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            dev_q[i].delete();
            dev_dv[i] = 1'b0;
            d_rsp[i]  = '0;
        end
        h_req = '0;
        cur   = '0;
    endtask

    task automatic check_idle(input string tag);
        logic [NDEV-1:0] av;
        for (int i = 0; i < NDEV; i++) av[i] = d_req[i].a_valid;
        chk({tag, "_d_valid"}, 64'(h_rsp.d_valid), 64'(0));
        chk({tag, "_a_ready"}, 64'(h_rsp.a_ready), 64'(0));
        chk({tag, "_dev_a_valid"}, 64'(av), 64'(0));
    endtask

    initial begin
        force_first = 1'b0;
        rst_n = 1'b0;
        clear_models();
        #1;
        check_idle("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(400, 70, 50, 70, 15, 0, NDEV - 1);
        run(300, 90, 10, 60, 0, 0, 0);
        run(300, 80, 50, 60, 70, 0, NDEV - 1);
        run(200, 90, 30, 80, 0, 1, 3);
        run(150, 95, 5, 90, 0, 2, 2);

        @(negedge clk);
        rst_n = 1'b0;
        clear_models();
        #1;
        check_idle("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_first = 1'b1;

        run(400, 70, 50, 70, 15, 0, NDEV - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
